// File: rtl/control_unit.sv
// Purpose : multicycle MIPS-style control FSM (fetch/decode/execute/memory/write-back).
// Latency : Moore outputs follow the state register; lw=5, sw/R/addi=4, beq/j=3 cycles.
// Backpr. : none -- advances one state per clk edge unconditionally.
//
// Ports:
//   clk, reset_n            - clock, async active-low reset (forces FETCH immediately)
//   opcode, funct           - instr[31:26] / instr[5:0] from the instruction register
//   mem_to_reg .. reg_write - 1-bit datapath controls
//   alu_src_b, pc_src       - 2-bit datapath muxes; alu_control - 3-bit ALU op
//   state                   - current FSM encoding (debug only)
//   instr_done              - one-cycle pulse in the final cycle of every instruction
//   illegal_op              - trap flag, only live when CU_ILLEGAL_TRAP_EN is defined
//
// Optional feature macro: CU_ILLEGAL_TRAP_EN (unlisted opcode parks the FSM in TRAP).
module control_unit (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       mem_to_reg,
    output logic       reg_dest,
    output logic       i_or_d,
    output logic       alu_src_a,
    output logic       ir_write,
    output logic       mem_write,
    output logic       pc_write,
    output logic       branch,
    output logic       reg_write,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        JEX     = 4'd10,
        ADDIWB  = 4'd11,
        TRAP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_q;
    state_t state_d;

    // Raw state decodes of the write enables, before reset gating.
    logic ir_write_raw;
    logic pc_write_raw;
    logic mem_write_raw;
    logic reg_write_raw;
    logic branch_raw;
    logic instr_done_raw;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. opcode is only consulted in DECODE/MEMADR, funct
    // only in RTYPEEX, so IR changes elsewhere cannot steer the FSM.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
`ifdef CU_ILLEGAL_TRAP_EN
                    default:      state_d = TRAP;
`else
                    // Unlisted opcode retires as a silent 2-cycle NOP.
                    default:      state_d = FETCH;
`endif
                endcase
            end
            // Anything that is not a store is treated as a load here; DECODE
            // only lets lw/sw reach MEMADR.
            MEMADR:  state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_d = MEMWB;
            RTYPEEX: state_d = RTYPEWB;
            ADDIEX:  state_d = ADDIWB;
            MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX: state_d = FETCH;
`ifdef CU_ILLEGAL_TRAP_EN
            TRAP:    state_d = TRAP;    // held until reset
`else
            TRAP:    state_d = FETCH;   // unreachable in this build
`endif
            default: state_d = FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore output decode (alu_control additionally looks at funct in RTYPEEX)
    // ------------------------------------------------------------------
    always_comb begin
        mem_to_reg     = 1'b0;
        reg_dest       = 1'b0;
        i_or_d         = 1'b0;
        alu_src_a      = 1'b0;
        alu_src_b      = 2'b00;
        pc_src         = 2'b00;
        alu_control    = ALU_ADD;
        ir_write_raw   = 1'b0;
        pc_write_raw   = 1'b0;
        mem_write_raw  = 1'b0;
        reg_write_raw  = 1'b0;
        branch_raw     = 1'b0;
        instr_done_raw = 1'b0;
        illegal_op     = 1'b0;

        case (state_q)
            FETCH: begin
                ir_write_raw = 1'b1;
                pc_write_raw = 1'b1;
                alu_src_b    = 2'b01;
            end
            DECODE: begin
                alu_src_b = 2'b11;
            end
            MEMADR, ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                i_or_d = 1'b1;
            end
            MEMWB: begin
                reg_write_raw  = 1'b1;
                mem_to_reg     = 1'b1;
                instr_done_raw = 1'b1;
            end
            MEMWR: begin
                i_or_d         = 1'b1;
                mem_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
            end
            RTYPEEX: begin
                alu_src_a = 1'b1;
                case (funct)
                    6'b100000: alu_control = ALU_ADD;
                    6'b100010: alu_control = ALU_SUB;
                    6'b100100: alu_control = ALU_AND;
                    6'b100101: alu_control = ALU_OR;
                    6'b101010: alu_control = ALU_SLT;
                    default:   alu_control = ALU_ADD;
                endcase
            end
            RTYPEWB: begin
                reg_write_raw  = 1'b1;
                reg_dest       = 1'b1;
                instr_done_raw = 1'b1;
            end
            BEQEX: begin
                alu_src_a      = 1'b1;
                alu_control    = ALU_SUB;
                branch_raw     = 1'b1;
                pc_src         = 2'b01;
                instr_done_raw = 1'b1;
            end
            JEX: begin
                pc_write_raw   = 1'b1;
                pc_src         = 2'b10;
                instr_done_raw = 1'b1;
            end
            ADDIWB: begin
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
            end
            TRAP: begin
`ifdef CU_ILLEGAL_TRAP_EN
                illegal_op = 1'b1;
`endif
            end
            default: begin
            end
        endcase
    end

    // Async reset already parks state_q in FETCH, so the mux outputs show
    // FETCH values during reset; the enables are additionally masked so no
    // write can fire while reset_n is low.
    assign ir_write   = ir_write_raw   & reset_n;
    assign pc_write   = pc_write_raw   & reset_n;
    assign mem_write  = mem_write_raw  & reset_n;
    assign reg_write  = reg_write_raw  & reset_n;
    assign branch     = branch_raw     & reset_n;
    assign instr_done = instr_done_raw & reset_n;
    assign state      = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: reset behaviour, each opcode's state walk
// and output decodes, mid-instruction reset and unlisted-opcode handling.
module tb_control_unit;

    logic       clk;
    logic       reset_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_to_reg, reg_dest, i_or_d, alu_src_a, ir_write;
    logic       mem_write, pc_write, branch, reg_write;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic [3:0] state;
    logic       instr_done, illegal_op;

    int checks   = 0;
    int failures = 0;

    control_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .opcode      (opcode),
        .funct       (funct),
        .mem_to_reg  (mem_to_reg),
        .reg_dest    (reg_dest),
        .i_or_d      (i_or_d),
        .alu_src_a   (alu_src_a),
        .ir_write    (ir_write),
        .mem_write   (mem_write),
        .pc_write    (pc_write),
        .branch      (branch),
        .reg_write   (reg_write),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src),
        .alu_control (alu_control),
        .state       (state),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        opcode  = 6'b000000;
        funct   = 6'b000000;

        // ---------------- reset held for 3 cycles ----------------
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_state",    {4'b0, state},       8'd0);
            chk("rst_ir_write", {7'b0, ir_write},    8'd0);
            chk("rst_pc_write", {7'b0, pc_write},    8'd0);
            chk("rst_srcb",     {6'b0, alu_src_b},   8'd1);
            chk("rst_aluctl",   {5'b0, alu_control}, 8'd2);
            chk("rst_done",     {7'b0, instr_done},  8'd0);
            chk("rst_illegal",  {7'b0, illegal_op},  8'd0);
            tick();
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_state",    {4'b0, state},    8'd0);
        chk("rel_ir_write", {7'b0, ir_write}, 8'd1);
        chk("rel_pc_write", {7'b0, pc_write}, 8'd1);

        // ---------------- lw: 0,1,2,3,4 ----------------
        opcode = 6'b100011;
        chk("lw_s0_done", {7'b0, instr_done}, 8'd0);
        tick();
        chk("lw_s1", {4'b0, state}, 8'd1);
        chk("lw_s1_srcb", {6'b0, alu_src_b}, 8'd3);
        chk("lw_s1_regw", {7'b0, reg_write}, 8'd0);
        tick();
        chk("lw_s2", {4'b0, state}, 8'd2);
        chk("lw_s2_srca", {7'b0, alu_src_a}, 8'd1);
        chk("lw_s2_srcb", {6'b0, alu_src_b}, 8'd2);
        chk("lw_s2_done", {7'b0, instr_done}, 8'd0);
        tick();
        chk("lw_s3", {4'b0, state}, 8'd3);
        chk("lw_s3_iord", {7'b0, i_or_d}, 8'd1);
        chk("lw_s3_m2r",  {7'b0, mem_to_reg}, 8'd0);
        chk("lw_s3_done", {7'b0, instr_done}, 8'd0);
        tick();
        chk("lw_s4", {4'b0, state}, 8'd4);
        chk("lw_s4_regw", {7'b0, reg_write}, 8'd1);
        chk("lw_s4_m2r",  {7'b0, mem_to_reg}, 8'd1);
        chk("lw_s4_rdst", {7'b0, reg_dest}, 8'd0);
        chk("lw_s4_done", {7'b0, instr_done}, 8'd1);
        // Opcode change outside the sampling states must not matter.
        opcode = 6'b000010;
        tick();
        chk("lw_end", {4'b0, state}, 8'd0);
        chk("lw_end_done", {7'b0, instr_done}, 8'd0);

        // ---------------- R-type with three funct values ----------------
        opcode = 6'b000000;
        funct  = 6'b100010;
        tick(); tick();
        chk("rsub_s6", {4'b0, state}, 8'd6);
        chk("rsub_alu", {5'b0, alu_control}, 8'd6);
        chk("rsub_srca", {7'b0, alu_src_a}, 8'd1);
        chk("rsub_srcb", {6'b0, alu_src_b}, 8'd0);
        tick();
        chk("rsub_s7", {4'b0, state}, 8'd7);
        chk("rsub_rdst", {7'b0, reg_dest}, 8'd1);
        chk("rsub_regw", {7'b0, reg_write}, 8'd1);
        chk("rsub_done", {7'b0, instr_done}, 8'd1);
        chk("rsub_aluwb", {5'b0, alu_control}, 8'd2);
        tick();
        chk("rsub_end", {4'b0, state}, 8'd0);

        funct = 6'b101010;
        tick(); tick();
        chk("rslt_s6", {4'b0, state}, 8'd6);
        chk("rslt_alu", {5'b0, alu_control}, 8'd7);
        tick(); tick();

        funct = 6'b111111;
        tick(); tick();
        chk("rdef_s6", {4'b0, state}, 8'd6);
        chk("rdef_alu", {5'b0, alu_control}, 8'd2);
        funct = 6'b100100;
        #1;
        chk("rand_alu", {5'b0, alu_control}, 8'd0);
        funct = 6'b100101;
        #1;
        chk("ror_alu", {5'b0, alu_control}, 8'd1);
        tick(); tick();
        chk("rdef_end", {4'b0, state}, 8'd0);

        // ---------------- beq: 0,1,8,0 ----------------
        opcode = 6'b000100;
        tick(); tick();
        chk("beq_s8", {4'b0, state}, 8'd8);
        chk("beq_branch", {7'b0, branch}, 8'd1);
        chk("beq_pcsrc", {6'b0, pc_src}, 8'd1);
        chk("beq_alu", {5'b0, alu_control}, 8'd6);
        chk("beq_done", {7'b0, instr_done}, 8'd1);
        chk("beq_pcw", {7'b0, pc_write}, 8'd0);
        tick();
        chk("beq_end", {4'b0, state}, 8'd0);

        // ---------------- j: 0,1,10,0 ----------------
        opcode = 6'b000010;
        tick(); tick();
        chk("j_s10", {4'b0, state}, 8'd10);
        chk("j_pcw", {7'b0, pc_write}, 8'd1);
        chk("j_pcsrc", {6'b0, pc_src}, 8'd2);
        chk("j_done", {7'b0, instr_done}, 8'd1);
        tick();
        chk("j_end", {4'b0, state}, 8'd0);

        // ---------------- addi: 0,1,9,11,0 ----------------
        opcode = 6'b001000;
        tick(); tick();
        chk("addi_s9", {4'b0, state}, 8'd9);
        chk("addi_srcb", {6'b0, alu_src_b}, 8'd2);
        tick();
        chk("addi_s11", {4'b0, state}, 8'd11);
        chk("addi_regw", {7'b0, reg_write}, 8'd1);
        chk("addi_rdst", {7'b0, reg_dest}, 8'd0);
        chk("addi_m2r", {7'b0, mem_to_reg}, 8'd0);
        tick();
        chk("addi_end", {4'b0, state}, 8'd0);

        // ---------------- sw interrupted by reset in state 5 ----------------
        opcode = 6'b101011;
        tick(); tick(); tick();
        chk("sw_s5", {4'b0, state}, 8'd5);
        chk("sw_memw", {7'b0, mem_write}, 8'd1);
        chk("sw_iord", {7'b0, i_or_d}, 8'd1);
        reset_n = 1'b0;
        #1;
        chk("sw_rst_memw", {7'b0, mem_write}, 8'd0);
        chk("sw_rst_state", {4'b0, state}, 8'd0);
        chk("sw_rst_done", {7'b0, instr_done}, 8'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("sw_rel_state", {4'b0, state}, 8'd0);
        chk("sw_rel_irw", {7'b0, ir_write}, 8'd1);

        // ---------------- unlisted opcode ----------------
        opcode = 6'b111111;
        tick();
        chk("ill_s1", {4'b0, state}, 8'd1);
        chk("ill_s1_done", {7'b0, instr_done}, 8'd0);
        tick();
`ifdef CU_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            chk("trap_state", {4'b0, state}, 8'd12);
            chk("trap_flag", {7'b0, illegal_op}, 8'd1);
            chk("trap_pcw", {7'b0, pc_write}, 8'd0);
            chk("trap_irw", {7'b0, ir_write}, 8'd0);
            tick();
        end
        reset_n = 1'b0;
        #1;
        chk("trap_rst_state", {4'b0, state}, 8'd0);
        chk("trap_rst_flag", {7'b0, illegal_op}, 8'd0);
        reset_n = 1'b1;
`else
        chk("nop_state", {4'b0, state}, 8'd0);
        chk("nop_flag", {7'b0, illegal_op}, 8'd0);
        chk("nop_irw", {7'b0, ir_write}, 8'd1);
        tick();
        chk("nop_s1", {4'b0, state}, 8'd1);
        chk("nop_flag2", {7'b0, illegal_op}, 8'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
